ahb_slave_mux: RTL and testbench

AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

---
 rtl/ahb_mux_pkg.sv | 36 +++
 rtl/ahb_slave_mux_if.sv | 43 ++++
 rtl/ahb_prio_enc.sv | 32 +++
 rtl/ahb_slave_mux.sv | 116 +++++++++++
 tb/tb_ahb_slave_mux.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ahb_mux_pkg.sv
// ----------------------------------------------------------------------------
// ahb_mux_pkg
// Shared definitions for the AHB slave-side read/response multiplexer:
//   - mux_state_e : data-phase owner state (default-OK, slave, error 1/2)
//   - HTRANS_*    : AHB transfer-type encodings
//   - HRESP_*     : AHB response encodings
//   - is_transfer : true for HTRANS values that request a real transfer
// ----------------------------------------------------------------------------
package ahb_mux_pkg;

    typedef enum logic [1:0] {
        DFLT_OK = 2'd0,
        SLAVE   = 2'd1,
        ERR1    = 2'd2,
        ERR2    = 2'd3
    } mux_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ/SEQ to an unmapped address must be answered with an ERROR;
    // IDLE/BUSY to an unmapped address get a zero-wait OKAY.
    function automatic logic is_transfer(input logic [1:0] htrans);
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mux_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_mux_if
// Bus bundle between the AHB decoder/master side and the slave multiplexer.
//   HSEL      : address-phase slave select (intended one-hot)
//   HTRANS    : address-phase transfer type
//   HREADYOUT : per-slave ready
//   HRESP_S   : per-slave response (1 = ERROR)
//   HRDATA_S  : flattened per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   HREADY    : muxed ready back to master and slaves
//   HRESP     : muxed response
//   HRDATA    : muxed read data
//   dataSel   : registered data-phase owner index (NUM_SLAVES = default slave)
//   selError  : sticky multi-hot HSEL flag
// Modports: slave = the multiplexer's view, master = the driving side.
// ----------------------------------------------------------------------------
interface ahb_slave_mux_if #(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 64
);
    localparam int SW = $clog2(NUM_SLAVES) + 1;

    logic [NUM_SLAVES-1:0]            HSEL;
    logic [1:0]                       HTRANS;
    logic [NUM_SLAVES-1:0]            HREADYOUT;
    logic [NUM_SLAVES-1:0]            HRESP_S;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
    logic                             HREADY;
    logic                             HRESP;
    logic [DATA_WIDTH-1:0]            HRDATA;
    logic [SW-1:0]                    dataSel;
    logic                             selError;

    modport slave (
        input  HSEL, HTRANS, HREADYOUT, HRESP_S, HRDATA_S,
        output HREADY, HRESP, HRDATA, dataSel, selError
    );

    modport master (
        output HSEL, HTRANS, HREADYOUT, HRESP_S, HRDATA_S,
        input  HREADY, HRESP, HRDATA, dataSel, selError
    );

endinterface

// File: rtl/ahb_prio_enc.sv
// ----------------------------------------------------------------------------
// ahb_prio_enc
// Lowest-index priority encoder for the HSEL vector.
//   req_i   : request vector (HSEL)
//   idx_o   : index of the lowest set bit (0 when nothing is set)
//   any_o   : at least one bit set
//   multi_o : more than one bit set
// ----------------------------------------------------------------------------
module ahb_prio_enc #(
    parameter int WIDTH = 2,
    localparam int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             multi_o
);

    always_comb begin
        idx_o = '0;
        // Scan from the top down so the lowest set bit is the last writer.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        any_o   = |req_i;
        // Clearing the lowest set bit leaves something only if >1 bit was set.
        multi_o = (req_i & (req_i - WIDTH'(1))) != '0;
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// ahb_slave_mux
// AHB slave-side multiplexer with built-in default slave. The address phase
// is sampled on HCLK edges where HREADY=1 and decides who owns the following
// data phase; the outputs are then muxed combinationally from that owner.
// Unmapped NONSEQ/SEQ transfers receive the two-cycle AHB ERROR response.
//   HCLK   : bus clock
//   HRESET : synchronous active-high reset
//   bus    : ahb_slave_mux_if.slave (HSEL/HTRANS/HREADYOUT/HRESP_S/HRDATA_S
//            in; HREADY/HRESP/HRDATA/dataSel/selError out)
// ----------------------------------------------------------------------------
module ahb_slave_mux #(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_slave_mux_if.slave bus
);
    import ahb_mux_pkg::*;

    localparam int            SW       = $clog2(NUM_SLAVES) + 1;
    localparam logic [SW-1:0] DFLT_IDX = SW'(NUM_SLAVES);

    mux_state_e            state_q, state_d;
    logic [SW-1:0]         data_sel_q, data_sel_d;
    logic                  sel_error_q, sel_error_d;

    logic [SW-1:0]         enc_idx;
    logic                  enc_any;
    logic                  enc_multi;

    logic                  hready;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    ahb_prio_enc #(
        .WIDTH (NUM_SLAVES)
    ) u_enc (
        .req_i   (bus.HSEL),
        .idx_o   (enc_idx),
        .any_o   (enc_any),
        .multi_o (enc_multi)
    );

    // Output mux: purely a function of the registered data-phase owner.
    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = '0;
        case (state_q)
            SLAVE: begin
                // Compare against each legal index rather than indexing with
                // data_sel_q directly, whose range also covers the default slave.
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (data_sel_q == SW'(i)) begin
                        hready = bus.HREADYOUT[i];
                        hresp  = bus.HRESP_S[i];
                        hrdata = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            ERR2: begin
                hresp  = HRESP_ERROR;
            end
            default: begin
                hready = 1'b1;
            end
        endcase
    end

    // Next-state: ERR1 always advances to ERR2; otherwise a new address
    // phase is taken only when the current data phase completes (HREADY=1).
    always_comb begin
        state_d     = state_q;
        data_sel_d  = data_sel_q;
        sel_error_d = sel_error_q;
        if (state_q == ERR1) begin
            state_d = ERR2;
        end else if (hready) begin
            if (enc_any) begin
                state_d    = SLAVE;
                data_sel_d = enc_idx;
                if (enc_multi) begin
                    sel_error_d = 1'b1;
                end
            end else begin
                data_sel_d = DFLT_IDX;
                state_d    = is_transfer(bus.HTRANS) ? ERR1 : DFLT_OK;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= DFLT_OK;
            data_sel_q  <= DFLT_IDX;
            sel_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_sel_q  <= data_sel_d;
            sel_error_q <= sel_error_d;
        end
    end

    assign bus.HREADY   = hready;
    assign bus.HRESP    = hresp;
    assign bus.HRDATA   = hrdata;
    assign bus.dataSel  = data_sel_q;
    assign bus.selError = sel_error_q;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mux
// Scoreboard bench for ahb_slave_mux: instance A (2 slaves x 64 bits) and
// instance B (4 slaves x 32 bits). Each stimulus cycle pushes the expected
// outputs for that cycle; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mux;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NSEQ = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;

    localparam logic [63:0] D0 = 64'hABCDEF1234567890;
    localparam logic [63:0] D1 = 64'h1234567890ABCDEF;

    localparam logic [31:0] B0 = 32'h34567890;
    localparam logic [31:0] B1 = 32'h11112222;
    localparam logic [31:0] B2 = 32'h33334444;
    localparam logic [31:0] B3 = 32'h55556666;

    typedef struct {
        string       name;
        bit          dut_b;
        logic        rdy;
        logic        resp;
        logic [63:0] data;
        logic [3:0]  sel;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic HCLK = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 HCLK = ~HCLK;

    ahb_slave_mux_if #(.NUM_SLAVES(2), .DATA_WIDTH(64)) a_if ();
    ahb_slave_mux_if #(.NUM_SLAVES(4), .DATA_WIDTH(32)) b_if ();

    ahb_slave_mux #(.NUM_SLAVES(2), .DATA_WIDTH(64)) u_a (
        .HCLK   (HCLK),
        .HRESET (rst_a),
        .bus    (a_if)
    );

    ahb_slave_mux #(.NUM_SLAVES(4), .DATA_WIDTH(32)) u_b (
        .HCLK   (HCLK),
        .HRESET (rst_b),
        .bus    (b_if)
    );

    task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, exp);
        end
    endtask

    // Monitor: compares whatever the stimulus has queued for this cycle.
    always @(negedge HCLK) begin : monitor
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (!e.dut_b) begin
                chk(e.name, "HREADY",   {63'b0, a_if.HREADY},   {63'b0, e.rdy});
                chk(e.name, "HRESP",    {63'b0, a_if.HRESP},    {63'b0, e.resp});
                chk(e.name, "HRDATA",   a_if.HRDATA,            e.data);
                chk(e.name, "dataSel",  {62'b0, a_if.dataSel},  {60'b0, e.sel});
                chk(e.name, "selError", {63'b0, a_if.selError}, {63'b0, e.err});
            end else begin
                chk(e.name, "HREADY",   {63'b0, b_if.HREADY},   {63'b0, e.rdy});
                chk(e.name, "HRESP",    {63'b0, b_if.HRESP},    {63'b0, e.resp});
                chk(e.name, "HRDATA",   {32'b0, b_if.HRDATA},   e.data);
                chk(e.name, "dataSel",  {61'b0, b_if.dataSel},  {60'b0, e.sel});
                chk(e.name, "selError", {63'b0, b_if.selError}, {63'b0, e.err});
            end
        end
    end

    // Drive one cycle of inputs, queue that cycle's expected outputs, advance.
    task automatic step(input bit b, input string n, input logic rst,
                        input logic [3:0] sel, input logic [1:0] tr,
                        input logic [3:0] rdy, input logic [3:0] rsp,
                        input logic e_rdy, input logic e_resp,
                        input logic [63:0] e_data, input logic [3:0] e_sel,
                        input logic e_err);
        exp_t e;
        if (!b) begin
            rst_a          = rst;
            a_if.HSEL      = sel[1:0];
            a_if.HTRANS    = tr;
            a_if.HREADYOUT = rdy[1:0];
            a_if.HRESP_S   = rsp[1:0];
        end else begin
            rst_b          = rst;
            b_if.HSEL      = sel;
            b_if.HTRANS    = tr;
            b_if.HREADYOUT = rdy;
            b_if.HRESP_S   = rsp;
        end
        e.name  = n;
        e.dut_b = b;
        e.rdy   = e_rdy;
        e.resp  = e_resp;
        e.data  = e_data;
        e.sel   = e_sel;
        e.err   = e_err;
        q.push_back(e);
        @(posedge HCLK);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        rst_a          = 1'b1;
        rst_b          = 1'b1;
        a_if.HSEL      = '0;
        a_if.HTRANS    = T_IDLE;
        a_if.HREADYOUT = '1;
        a_if.HRESP_S   = '0;
        a_if.HRDATA_S  = {D1, D0};
        b_if.HSEL      = '0;
        b_if.HTRANS    = T_IDLE;
        b_if.HREADYOUT = '1;
        b_if.HRESP_S   = '0;
        b_if.HRDATA_S  = {B3, B2, B1, B0};
        @(posedge HCLK);
        #1;

        // ---------------- instance A: 2 slaves, 64-bit ----------------
        //      dut  name        rst   HSEL   HTRANS  RDY    RSP    rdy  resp data   sel  err
        step(0, "a_reset",    1'b1, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_idle1",    1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_idle2",    1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_idle3",    1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_addr_s0",  1'b0, 4'h1, T_NSEQ, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_data_s0",  1'b0, 4'h2, T_NSEQ, 4'h3, 4'h0, 1'b1, 1'b0, D0,    4'd0, 1'b0);
        step(0, "a_wait1_s1", 1'b0, 4'h1, T_NSEQ, 4'h1, 4'h0, 1'b0, 1'b0, D1,    4'd1, 1'b0);
        step(0, "a_wait2_s1", 1'b0, 4'h0, T_NSEQ, 4'h1, 4'h0, 1'b0, 1'b0, D1,    4'd1, 1'b0);
        step(0, "a_data_s1",  1'b0, 4'h1, T_NSEQ, 4'h3, 4'h0, 1'b1, 1'b0, D1,    4'd1, 1'b0);
        step(0, "a_after_s0", 1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, D0,    4'd0, 1'b0);
        step(0, "a_unmapped", 1'b0, 4'h0, T_NSEQ, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_err1",     1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b0, 1'b1, 64'h0, 4'd2, 1'b0);
        step(0, "a_err2",     1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b1, 64'h0, 4'd2, 1'b0);
        step(0, "a_multi",    1'b0, 4'h3, T_SEQ,  4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_multi_dp", 1'b0, 4'h2, T_NSEQ, 4'h3, 4'h1, 1'b1, 1'b1, D0,    4'd0, 1'b1);
        step(0, "a_s1_sticky",1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, D1,    4'd1, 1'b1);
        step(0, "a_sticky",   1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b1);
        step(0, "a_unmap2",   1'b0, 4'h0, T_SEQ,  4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b1);
        step(0, "a_rst_err1", 1'b1, 4'h1, T_NSEQ, 4'h3, 4'h0, 1'b0, 1'b1, 64'h0, 4'd2, 1'b1);
        step(0, "a_post_rst", 1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_busy",     1'b0, 4'h0, T_BUSY, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_after_bsy",1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_unmap3",   1'b0, 4'h0, T_NSEQ, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);
        step(0, "a_err1_hold",1'b0, 4'h2, T_NSEQ, 4'h3, 4'h0, 1'b0, 1'b1, 64'h0, 4'd2, 1'b0);
        step(0, "a_err2_smp", 1'b0, 4'h2, T_NSEQ, 4'h3, 4'h0, 1'b1, 1'b1, 64'h0, 4'd2, 1'b0);
        step(0, "a_s1_aftere",1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, D1,    4'd1, 1'b0);
        step(0, "a_final",    1'b0, 4'h0, T_IDLE, 4'h3, 4'h0, 1'b1, 1'b0, 64'h0, 4'd2, 1'b0);

        // ---------------- instance B: 4 slaves, 32-bit ----------------
        step(1, "b_reset",    1'b1, 4'h0, T_IDLE, 4'hF, 4'h0, 1'b1, 1'b0, 64'h0,        4'd4, 1'b0);
        step(1, "b_addr_s0",  1'b0, 4'h1, T_NSEQ, 4'hF, 4'h0, 1'b1, 1'b0, 64'h0,        4'd4, 1'b0);
        step(1, "b_data_s0",  1'b0, 4'h8, T_NSEQ, 4'hF, 4'h0, 1'b1, 1'b0, {32'h0, B0},  4'd0, 1'b0);
        step(1, "b_data_s3",  1'b0, 4'h6, T_SEQ,  4'hF, 4'h0, 1'b1, 1'b0, {32'h0, B3},  4'd3, 1'b0);
        step(1, "b_multi_s1", 1'b0, 4'h0, T_IDLE, 4'hF, 4'h0, 1'b1, 1'b0, {32'h0, B1},  4'd1, 1'b1);
        step(1, "b_idle",     1'b0, 4'h0, T_IDLE, 4'hF, 4'h0, 1'b1, 1'b0, 64'h0,        4'd4, 1'b1);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
